clb_config_loader: RTL and testbench
====================================

// Module: clb_config_loader
// PURPOSE
//  Deserialises a beat-wide configuration stream into a CFG_WIDTH-bit word.
//  Commits the word to the CLB mux/LUT slice by driving config_out and pulsing comb_set.
//  Sits directly upstream of the F7/F8 mux slice; that slice captures config_in on posedge clk while comb_set=1.
//  Staging is separate from config_out, so the slice keeps its old config until commit.
// PARAMETERS
//  CFG_WIDTH  64  total configuration bits delivered to the slice (>=1)
//  BEAT_W     8   bits accepted per handshake beat (1..CFG_WIDTH)
//  NBEATS     derived localparam = ceil(CFG_WIDTH/BEAT_W)
// PORTS
//  clk           in   1          single clock, all state on posedge
//  rst_n         in   1          asynchronous active-low reset
//  cfg_start     in   1          1-cycle request to begin a new frame
//  cfg_in_data   in   BEAT_W     configuration beat
//  cfg_in_valid  in   1          beat valid
//  cfg_in_ready  out  1          loader accepts beat (high only in LOAD/PAR)
//  config_out    out  CFG_WIDTH  committed configuration word to slice config_in
//  comb_set      out  1          1-cycle commit strobe to slice
//  cfg_busy      out  1          high in LOAD, PAR, COMMIT
//  cfg_done      out  1          sticky: last frame committed
//  cfg_err       out  1          sticky: last frame rejected (parity)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; beat_cnt=0; staging=0; config_out=0; all status/strobe outputs 0.
//  Beat transfer occurs when cfg_in_valid && cfg_in_ready on a posedge.
//  FSM states: IDLE, LOAD, PAR (only with CFG_PARITY_EN), COMMIT.
//   IDLE -> LOAD on cfg_start; clear staging, beat_cnt, cfg_done, cfg_err.
//   LOAD: beat k is written to staging[k*BEAT_W +: BEAT_W] (LSB-first).
//    In the last beat, bits above CFG_WIDTH-1 are discarded. beat_cnt increments per transfer.
//    The transfer with beat_cnt==NBEATS-1 -> COMMIT (or PAR if CFG_PARITY_EN).
//   COMMIT: lasts exactly 1 cycle; comb_set=1; config_out already equals staging.
//    config_out is loaded on the edge entering COMMIT, so it is stable for the whole strobe cycle.
//    Next cycle: IDLE, with cfg_done=1.
//  Latency: last beat accepted at edge N -> comb_set high during cycle N..N+1 -> IDLE after edge N+1.
//  comb_set is registered, never combinational from inputs; exactly one pulse per good frame.
//  cfg_in_ready=0 in IDLE/COMMIT: valid beats there are not consumed (the source holds them).
//  cfg_start in LOAD/PAR: abort and restart.
//   Staging and beat_cnt clear; state stays LOAD; no comb_set; config_out unchanged.
//   A beat presented in that same cycle is dropped.
//  cfg_start during COMMIT: ignored (the commit completes).
//  cfg_start + cfg_in_valid in the same IDLE cycle: the beat is not accepted.
//  Async reset mid-frame: the partial frame is lost; config_out returns to 0; no comb_set.
//  beat_cnt width is clog2(NBEATS+1); it never wraps because it clears on commit/start.
// CONFIGURATION
//  CFG_PARITY_EN defined:
//   After the data beats, LOAD -> PAR, which accepts 1 beat; only bit 0 is used.
//   Check: bit0 must equal XOR of staging[CFG_WIDTH-1:0] (even parity over data+bit).
//   Match -> COMMIT as above.
//   Mismatch -> IDLE; cfg_err=1; no comb_set; config_out unchanged.
//  CFG_PARITY_EN undefined: no PAR state; no extra beat; cfg_err tied 0.
// TESTING  (CFG_WIDTH=20, BEAT_W=8, NBEATS=3)
//  1. Reset, then start; beats 0xA5,0x3C,0xF7 back-to-back ->
//     config_out=20'h73CA5; one comb_set pulse 1 cycle after the 3rd beat; cfg_done=1.
//  2. Valid toggles 1/0 with random gaps -> same config_out; comb_set count=1; ready low in IDLE.
//  3. Two beats (0x11,0x22), then cfg_start, then 0x01,0x02,0x03 ->
//     config_out=20'h30201; exactly one comb_set; old config held until commit.
//  4. rst_n low after 2nd beat -> all outputs 0 immediately (async).
//     The next full frame 0xFF,0xFF,0xFF -> config_out=20'hFFFFF.
//  5. CFG_PARITY_EN: data 0x01,0x00,0x00 + parity beat 0x01 -> commit 20'h00001.
//     Same data with parity 0x00 -> cfg_err=1, no comb_set, config_out unchanged.
//  6. cfg_start asserted during the COMMIT cycle -> ignored.
//     comb_set=1 for 1 cycle; state returns to IDLE; cfg_done=1.

Source files
------------

// File: rtl/clb_config_loader_if.sv
// clb_config_loader_if: configuration beat stream in, committed word and status out.
interface clb_config_loader_if #(
    parameter int CFG_WIDTH = 64,
    parameter int BEAT_W    = 8
);
    logic                 cfg_start;
    logic [BEAT_W-1:0]    cfg_in_data;
    logic                 cfg_in_valid;
    logic                 cfg_in_ready;
    logic [CFG_WIDTH-1:0] config_out;
    logic                 comb_set;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;

    modport master (
        output cfg_start, cfg_in_data, cfg_in_valid,
        input  cfg_in_ready, config_out, comb_set, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_in_data, cfg_in_valid,
        output cfg_in_ready, config_out, comb_set, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/clb_config_loader.sv
// clb_config_loader: deserialises LSB-first beats into a staging word and commits it to the mux slice.
// Define CFG_PARITY_EN to add a trailing even-parity beat that must match before commit.
module clb_config_loader #(
    parameter int CFG_WIDTH = 64,
    parameter int BEAT_W    = 8
) (
    input logic                clk,
    input logic                rst_n,
    clb_config_loader_if.slave bus
);
    localparam int NBEATS = (CFG_WIDTH + BEAT_W - 1) / BEAT_W;
    localparam int CW     = $clog2(NBEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

`ifdef CFG_PARITY_EN
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0]   stage_q, stage_d;
    logic [CFG_WIDTH-1:0]   out_q, out_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [NBEATS*BEAT_W-1:0] wide;
    logic                   ready, xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The last beat may overhang CFG_WIDTH; the padded view lets the excess fall off.
    always_comb begin
        wide = '0;
        wide[CFG_WIDTH-1:0] = stage_q;
        wide[cnt_q*BEAT_W +: BEAT_W] = bus.cfg_in_data;
    end

    assign ready = (state_q == LOAD)
`ifdef CFG_PARITY_EN
                 | (state_q == PAR)
`endif
                 ;
    assign xfer = ready & bus.cfg_in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        out_d   = out_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.cfg_start) begin
                state_d = LOAD;
                cnt_d   = '0;
                stage_d = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            LOAD: if (bus.cfg_start) begin
                cnt_d   = '0;
                stage_d = '0;
            end else if (xfer) begin
                stage_d = wide[CFG_WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef CFG_PARITY_EN
                    state_d = PAR;
`else
                    state_d = COMMIT;
                    out_d   = wide[CFG_WIDTH-1:0];
`endif
                end
            end
`ifdef CFG_PARITY_EN
            PAR: if (bus.cfg_start) begin
                state_d = LOAD;
                cnt_d   = '0;
                stage_d = '0;
            end else if (xfer) begin
                if (bus.cfg_in_data[0] == ^stage_q) begin
                    state_d = COMMIT;
                    out_d   = stage_q;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
`endif
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_in_ready = ready;
        bus.config_out   = out_q;
        bus.comb_set     = state_q == COMMIT;
        bus.cfg_busy     = state_q != IDLE;
        bus.cfg_done     = done_q;
        bus.cfg_err      = err_q;
    end
endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: randomized frames against a byte-packing reference model, 20-bit word, 8-bit beats.
module tb_clb_config_loader;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic [19:0] prev_cfg = '0;

    always #5 clk = ~clk;

    clb_config_loader_if #(.CFG_WIDTH(20), .BEAT_W(8)) bus();
    clb_config_loader #(.CFG_WIDTH(20), .BEAT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always @(negedge clk) if (bus.comb_set === 1'b1) pulses++;

    function automatic logic [19:0] pack(input logic [7:0] b0, b1, b2);
        logic [23:0] w;
        w = {b2, b1, b0};
        return w[19:0];
    endfunction

    task automatic pulse_start();
        @(negedge clk); bus.cfg_in_valid = 1'b0; bus.cfg_start = 1'b1;
        @(negedge clk); bus.cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input int gap);
        int t = 0;
        repeat (gap) begin @(negedge clk); bus.cfg_in_valid = 1'b0; end
        @(negedge clk);
        bus.cfg_in_valid = 1'b0;
        while (bus.cfg_in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (t >= 50) begin errors++; $display("FAIL ready_timeout got ready=%b want 1", bus.cfg_in_ready); end
        bus.cfg_in_data = d; bus.cfg_in_valid = 1'b1;
        @(posedge clk);
    endtask

`ifdef CFG_PARITY_EN
    task automatic send_par(input logic [19:0] d, input logic bad, input int gap);
        send_beat({7'b0, (^d) ^ bad}, gap);
    endtask
`endif

    task automatic finish_frame(input logic [19:0] exp, input logic good, input int p0);
        @(negedge clk); bus.cfg_in_valid = 1'b0;
        checks += 2;
        if (bus.comb_set !== good) begin errors++; $display("FAIL commit_strobe got %b want %b", bus.comb_set, good); end
        if (bus.config_out !== exp) begin errors++; $display("FAIL config_out got %h want %h", bus.config_out, exp); end
        @(negedge clk);
        checks += 5;
        if (bus.comb_set !== 1'b0) begin errors++; $display("FAIL strobe_width got %b want 0", bus.comb_set); end
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", bus.cfg_busy); end
        if (bus.cfg_done !== good) begin errors++; $display("FAIL done got %b want %b", bus.cfg_done, good); end
        if (bus.cfg_err !== !good) begin errors++; $display("FAIL err got %b want %b", bus.cfg_err, !good); end
        if (pulses - p0 !== int'(good)) begin errors++; $display("FAIL pulse_count got %0d want %0d", pulses - p0, int'(good)); end
        prev_cfg = exp;
    endtask

    task automatic run_frame(input logic [7:0] b0, b1, b2, input int maxgap, input logic bad);
        int p0 = pulses;
        logic [19:0] exp;
        exp = pack(b0, b1, b2);
        pulse_start();
        send_beat(b0, $urandom_range(0, maxgap));
        send_beat(b1, $urandom_range(0, maxgap));
        send_beat(b2, $urandom_range(0, maxgap));
`ifdef CFG_PARITY_EN
        send_par(exp, bad, $urandom_range(0, maxgap));
`endif
        finish_frame(bad ? prev_cfg : exp, !bad, p0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (bus.config_out !== 20'h0) begin errors++; $display("FAIL rst_config got %h want 0", bus.config_out); end
        if (bus.comb_set !== 1'b0) begin errors++; $display("FAIL rst_comb_set got %b want 0", bus.comb_set); end
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.cfg_busy); end
        if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_status got %b%b want 00", bus.cfg_done, bus.cfg_err); end
        if (bus.cfg_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.cfg_in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(8'hA5, 8'h3C, 8'hF7, 0, 1'b0);
        checks++;
        if (prev_cfg !== 20'h73CA5) begin errors++; $display("FAIL basic_model got %h want 73ca5", prev_cfg); end
    endtask

    task automatic test_gaps();
        @(negedge clk); bus.cfg_in_valid = 1'b1; bus.cfg_in_data = 8'h55;
        @(negedge clk);
        checks += 2;
        if (bus.cfg_in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", bus.cfg_in_ready); end
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.cfg_busy); end
        bus.cfg_in_valid = 1'b0;
        run_frame(8'hA5, 8'h3C, 8'hF7, 3, 1'b0);
    endtask

    task automatic test_random();
        repeat (8) run_frame(8'($urandom), 8'($urandom), 8'($urandom), 3, 1'b0);
    endtask

    task automatic test_abort();
        int p0 = pulses;
        pulse_start();
        send_beat(8'h11, 0);
        send_beat(8'h22, 0);
        @(negedge clk);
        checks += 2;
        if (bus.config_out !== prev_cfg) begin errors++; $display("FAIL abort_hold got %h want %h", bus.config_out, prev_cfg); end
        if (bus.comb_set !== 1'b0) begin errors++; $display("FAIL abort_strobe got %b want 0", bus.comb_set); end
        bus.cfg_start = 1'b1; bus.cfg_in_valid = 1'b1; bus.cfg_in_data = 8'h99;
        @(negedge clk); bus.cfg_start = 1'b0; bus.cfg_in_valid = 1'b0;
        checks++;
        if (bus.config_out !== prev_cfg) begin errors++; $display("FAIL restart_hold got %h want %h", bus.config_out, prev_cfg); end
        send_beat(8'h01, 0);
        send_beat(8'h02, 0);
        send_beat(8'h03, 0);
`ifdef CFG_PARITY_EN
        send_par(20'h30201, 1'b0, 0);
`endif
        finish_frame(20'h30201, 1'b1, p0);
    endtask

    task automatic test_start_with_beat();
        int p0 = pulses;
        @(negedge clk); bus.cfg_start = 1'b1; bus.cfg_in_valid = 1'b1; bus.cfg_in_data = 8'hEE;
        @(negedge clk); bus.cfg_start = 1'b0; bus.cfg_in_valid = 1'b0;
        send_beat(8'h12, 1);
        send_beat(8'h34, 0);
        send_beat(8'h56, 2);
`ifdef CFG_PARITY_EN
        send_par(20'h63412, 1'b0, 0);
`endif
        finish_frame(20'h63412, 1'b1, p0);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_beat(8'hAA, 0);
        send_beat(8'hBB, 0);
        @(negedge clk); bus.cfg_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.config_out !== 20'h0) begin errors++; $display("FAIL async_config got %h want 0", bus.config_out); end
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", bus.cfg_busy); end
        if (bus.comb_set !== 1'b0) begin errors++; $display("FAIL async_strobe got %b want 0", bus.comb_set); end
        if (bus.cfg_in_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b want 0", bus.cfg_in_ready); end
        @(negedge clk); rst_n = 1'b1;
        prev_cfg = '0;
        run_frame(8'hFF, 8'hFF, 8'hFF, 2, 1'b0);
    endtask

    task automatic test_start_in_commit();
        logic [19:0] exp;
        exp = pack(8'h5A, 8'hC3, 8'h0E);
        pulse_start();
        send_beat(8'h5A, 0);
        send_beat(8'hC3, 0);
        send_beat(8'h0E, 0);
`ifdef CFG_PARITY_EN
        send_par(exp, 1'b0, 0);
`endif
        @(negedge clk); bus.cfg_in_valid = 1'b0; bus.cfg_start = 1'b1;
        checks += 2;
        if (bus.comb_set !== 1'b1) begin errors++; $display("FAIL commit_start_strobe got %b want 1", bus.comb_set); end
        if (bus.config_out !== exp) begin errors++; $display("FAIL commit_start_cfg got %h want %h", bus.config_out, exp); end
        @(negedge clk); bus.cfg_start = 1'b0;
        checks += 3;
        if (bus.comb_set !== 1'b0) begin errors++; $display("FAIL commit_start_once got %b want 0", bus.comb_set); end
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL commit_start_idle got %b want 0", bus.cfg_busy); end
        if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL commit_start_done got %b want 1", bus.cfg_done); end
        @(negedge clk);
        checks++;
        if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL commit_start_ignored got %b want 0", bus.cfg_busy); end
        prev_cfg = exp;
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity();
        run_frame(8'h01, 8'h00, 8'h00, 0, 1'b0);
        run_frame(8'h01, 8'h00, 8'h00, 0, 1'b1);
        checks++;
        if (bus.config_out !== 20'h00001) begin errors++; $display("FAIL parity_hold got %h want 00001", bus.config_out); end
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 2, 1'b1);
    endtask
`endif

    initial begin
        bus.cfg_start = 1'b0; bus.cfg_in_valid = 1'b0; bus.cfg_in_data = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_random();
        test_abort();
        test_start_with_beat();
        test_reset_mid();
        test_start_in_commit();
`ifdef CFG_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
